// File: rtl/test_iterator.sv
// Sample-stepping stage: latches one triangle plus its snapped bounding box and
// walks every sample point of the box in raster order, one candidate per cycle.
module test_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [VERTS*AXIS*SIGFIG-1:0]  tri_R13S,
    input  logic [COLORS*SIGFIG-1:0]      color_R13U,
    input  logic [2*2*SIGFIG-1:0]         box_R13S,
    input  logic                          validTri_R13H,
    input  logic [3:0]                    subSample_RnnnnU,
    output logic                          halt_RnnnnL,
    output logic [VERTS*AXIS*SIGFIG-1:0]  tri_R14S,
    output logic [COLORS*SIGFIG-1:0]      color_R14U,
    output logic [2*SIGFIG-1:0]           sample_R14S,
    output logic                          validSamp_R14H
);

    typedef enum logic {
        WAIT = 1'b0,
        TEST = 1'b1
    } state_t;

    state_t                          r_state;
    logic [VERTS*AXIS*SIGFIG-1:0]    r_tri;
    logic [COLORS*SIGFIG-1:0]        r_color;
    logic signed [SIGFIG-1:0]        r_llX;
    logic signed [SIGFIG-1:0]        r_urX;
    logic signed [SIGFIG-1:0]        r_urY;
    logic signed [SIGFIG-1:0]        r_sampX;
    logic signed [SIGFIG-1:0]        r_sampY;

    logic signed [SIGFIG-1:0]        w_step;
    logic signed [SIGFIG-1:0]        w_nextX;
    logic signed [SIGFIG-1:0]        w_nextY;
    logic                            w_xOver;
    logic                            w_yOver;
    logic                            w_last;
    logic                            w_accept;

    always_comb begin
        w_step = SIGFIG'(1) << RADIX;
        case (subSample_RnnnnU)
            4'b1000: w_step = SIGFIG'(1) << RADIX;
            4'b0100: w_step = SIGFIG'(1) << (RADIX - 1);
            4'b0010: w_step = SIGFIG'(1) << (RADIX - 2);
            4'b0001: w_step = SIGFIG'(1) << (RADIX - 3);
            default: w_step = SIGFIG'(1) << RADIX;
        endcase
    end

    assign w_nextX  = r_sampX + w_step;
    assign w_nextY  = r_sampY + w_step;
    assign w_xOver  = w_nextX > r_urX;
    assign w_yOver  = w_nextY > r_urY;
    assign w_last   = w_xOver && w_yOver;

    // Ready again on the final sample so the next box follows with no bubble.
    assign halt_RnnnnL = (r_state == WAIT) || ((r_state == TEST) && w_last);
    assign w_accept    = validTri_R13H && halt_RnnnnL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT;
            r_tri   <= '0;
            r_color <= '0;
            r_llX   <= '0;
            r_urX   <= '0;
            r_urY   <= '0;
            r_sampX <= '0;
            r_sampY <= '0;
        end else if (w_accept) begin
            r_state <= TEST;
            r_tri   <= tri_R13S;
            r_color <= color_R13U;
            r_llX   <= box_R13S[SIGFIG-1:0];
            r_urX   <= box_R13S[3*SIGFIG-1:2*SIGFIG];
            r_urY   <= box_R13S[4*SIGFIG-1:3*SIGFIG];
            r_sampX <= box_R13S[SIGFIG-1:0];
            r_sampY <= box_R13S[2*SIGFIG-1:SIGFIG];
        end else if (r_state == TEST) begin
            if (w_last) begin
                r_state <= WAIT;
            end else if (w_xOver) begin
                r_sampX <= r_llX;
                r_sampY <= w_nextY;
            end else begin
                r_sampX <= w_nextX;
            end
        end
    end

    assign tri_R14S       = r_tri;
    assign color_R14U     = r_color;
    assign sample_R14S    = {r_sampY, r_sampX};
    assign validSamp_R14H = (r_state == TEST);

endmodule
